// File: rtl/query_mem_pkg.sv
// Shared constants for the query patch memory (read and write sides).
//   DATA_WIDTH : width of one patch word
//   ADDR_WIDTH : RAM address width
//   DEPTH      : RAM depth in words (2**ADDR_WIDTH)
//   CNT_W      : counter width; one extra bit so a full-depth count fits
//   state_e    : read sequencer FSM encoding
package query_mem_pkg;
  localparam int DATA_WIDTH = 55;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_W      = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/patch_out_fifo2.sv
// Two-entry synchronous FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i this cycle
//   pop_i      : consume head_o this cycle (only when count_o != 0)
//   din_i      : word to write
//   head_o     : oldest stored word (registered)
//   count_o    : occupancy 0..2
// Push and pop may occur together; the caller guarantees no push while full
// unless a pop happens in the same cycle.
module patch_out_fifo2 #(
  parameter int W = 55
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // occupancy unchanged; the new word goes behind whatever remains
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/query_patch_reader.sv
// Read-side sequencer for the query patch RAM (sync read, 1-cycle latency).
// Streams num_patches words starting at base_adr to a valid/ready consumer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a transfer (sampled only in IDLE)
//   base_adr            : first RAM address (latched on start)
//   num_patches         : words to stream, 0..DEPTH (latched on start)
//   ram_ren, ram_radr   : RAM read port request
//   ram_rdata           : RAM data, valid the cycle after ram_ren
//   out_valid/ready/data/last : downstream stream
//   busy                : not idle
//   done                : one-cycle pulse after the final handshake
module query_patch_reader
  import query_mem_pkg::*;
#(
  parameter int DATA_WIDTH = query_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = query_mem_pkg::ADDR_WIDTH,
  parameter int DEPTH      = query_mem_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_adr,
  input  logic [ADDR_WIDTH:0]   num_patches,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_radr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [CW-1:0]         num_q, num_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         deliv_q, deliv_d;
  logic                  infl_q;
  logic [1:0]            fifo_cnt;
  logic                  pop;
  logic [2:0]            occ;

  assign pop = out_valid && out_ready;
  // words that will be held after this edge if no new read is issued
  assign occ = {1'b0, fifo_cnt} + 3'(infl_q) - 3'(pop);

  assign ram_ren   = (state_q == ST_STREAM) && (issued_q < num_q) && (occ < 3'd2);
  assign ram_radr  = adr_q;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_last  = out_valid && (deliv_q == num_q - CW'(1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    num_d    = num_q;
    issued_d = issued_q;
    deliv_d  = deliv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          adr_d    = base_adr;
          num_d    = num_patches;
          issued_d = '0;
          deliv_d  = '0;
          state_d  = (num_patches == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (ram_ren) begin
          adr_d    = adr_q + ADDR_WIDTH'(1);  // wraps modulo DEPTH
          issued_d = issued_q + CW'(1);
        end
        if (pop) deliv_d = deliv_q + CW'(1);
        if (pop && out_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      num_q    <= '0;
      issued_q <= '0;
      deliv_q  <= '0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      deliv_q  <= deliv_d;
      infl_q   <= ram_ren;
    end
  end

  patch_out_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .pop_i   (pop),
    .din_i   (ram_rdata),
    .head_o  (out_data),
    .count_o (fifo_cnt)
  );
endmodule

// File: tb/tb_query_patch_reader.sv
module tb_query_patch_reader;
  localparam int DW = 55;
  localparam int AW = 7;
  localparam int DP = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [AW:0]   num_patches = '0;
  logic          ram_ren;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  query_patch_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
    .num_patches(num_patches), .ram_ren(ram_ren), .ram_radr(ram_radr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // behavioural RAM: synchronous read, one-cycle latency
  logic [DW-1:0] mem [DP];
  always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_radr];

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;

  logic [DW-1:0] exp_dq[$];
  bit            exp_lq[$];
  logic [AW-1:0] exp_aq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic spurious(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endtask

  // consumer readiness
  initial forever begin
    @(posedge clk); #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // monitor: occupancy model, address/data scoreboard, handshake rules
  int            occ = 0;
  bit            infl = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;
  bit            exp_done_nxt = 0;
  bit            zero_req = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0; infl = 0; hold_v = 0; exp_done_nxt = 0;
    end else begin
      bit pop;
      bit el;
      pop = out_valid && out_ready;
      chk("valid_vs_words_held", out_valid, occ != 0);
      chk("done_pulse", done, exp_done_nxt);
      exp_done_nxt = 0;
      if (zero_req) begin exp_done_nxt = 1; zero_req = 0; end
      if (ram_ren) begin
        chk("credit_limit", (occ + int'(infl) - int'(pop)) < 2, 1);
        if (exp_aq.size() == 0) spurious("ram_ren_spurious");
        else chk("ram_radr", ram_radr, exp_aq.pop_front());
      end
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (!out_valid) chk("last_gated", out_last, 0);
      if (pop) begin
        if (exp_dq.size() == 0) spurious("out_spurious");
        else begin
          el = exp_lq.pop_front();
          chk("out_data", out_data, exp_dq.pop_front());
          chk("out_last", out_last, el);
          if (el) exp_done_nxt = 1;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      occ  = occ + int'(infl) - int'(pop);
      infl = ram_ren;
    end
  end

  task automatic push_expected(input int base, input int num);
    for (int i = 0; i < num; i++) begin
      logic [AW-1:0] a;
      a = AW'((base + i) % DP);
      exp_aq.push_back(a);
      exp_dq.push_back(mem[a]);
      exp_lq.push_back(i == num - 1);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DP; i++) mem[i] = DW'({$urandom, $urandom});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_ren"}, ram_ren, 0);
    chk({tag, "_ram_radr"}, ram_radr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // one transfer; cycle 0 is the cycle start is held high
  task automatic run(input int base, input int num, input int mode, input bit timing);
    int cyc, first, bound;
    rdy_mode = mode;
    bound = 10 * num + 50;
    @(posedge clk); #1;
    start = 1'b1; base_adr = AW'(base); num_patches = (AW+1)'(num);
    push_expected(base, num);
    if (num == 0) zero_req = 1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; first = -1;
    while (!done && cyc < bound) begin
      if (out_valid && first < 0) first = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      spurious("done_timeout");
    end else begin
      chk("busy_in_done", busy, 1);
      if (timing && num > 0) begin
        chk("first_valid_cycle", first, 3);
        chk("done_cycle", cyc, num + 3);
      end
      if (num == 0) begin
        chk("zero_done_cycle", cyc, 1);
        chk("zero_no_valid", first < 0, 1);
      end
    end
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_single", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // incrementing contents, ready held high
    for (int i = 0; i < DP; i++) mem[i] = DW'(i + 100);
    run(0, 5, 0, 1);

    // address wrap
    for (int i = 0; i < DP; i++) mem[i] = DW'(i);
    run(126, 4, 0, 1);

    // backpressure
    fill_random();
    run($urandom_range(0, DP - 1), 6, 1, 0);

    // empty transfer
    run($urandom_range(0, DP - 1), 0, 0, 1);

    // ignored restart, then reset mid-transfer
    begin
      int b;
      fill_random();
      rdy_mode = 0;
      b = $urandom_range(0, DP - 1);
      @(posedge clk); #1;
      start = 1'b1; base_adr = AW'(b); num_patches = 9'd8;
      push_expected(b, 8);
      @(posedge clk); #1;                       // cycle 1
      start = 1'b0;
      @(posedge clk); #1;                       // cycle 2: ignored start
      start = 1'b1; base_adr = AW'(b + 40); num_patches = 9'd3;
      @(posedge clk); #1;                       // cycle 3
      start = 1'b0;
      @(posedge clk); #1;                       // cycle 4
      @(posedge clk); #1;                       // cycle 5
      rst_n = 1'b0;
      chk("words_before_reset", exp_dq.size(), 6);
      exp_dq.delete(); exp_lq.delete(); exp_aq.delete();
      @(negedge clk);
      check_all_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_ren", ram_ren, 0);
      end
      run($urandom_range(0, DP - 1), 2, 0, 1);
    end

    // full depth with wrap, ready high
    fill_random();
    run(64, 128, 0, 1);

    // random transfers under random backpressure
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run($urandom_range(0, DP - 1), $urandom_range(1, 40), 1, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_dq.size(), 0);
    chk("addr_queue_drained", exp_aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/query_patch_reader.md
Name: query_patch_reader

Overview:
- Read-side sequencer for the query patch RAM (1r1w, synchronous read, 1-cycle latency).
- Streams a block of stored query patches to a downstream compute consumer over a valid/ready handshake.
- Issues ram_ren/ram_radr, tracks in-flight reads, and buffers returned words in a 2-entry output FIFO so that backpressure never drops data.
- Sits between the query patch memory and the search/compute datapath.

Parameters:
- DATA_WIDTH, 55, width of one patch word.
- ADDR_WIDTH, 7, RAM address width.
- DEPTH, 128, RAM depth in words. DEPTH equals 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- base_adr  in  ADDR_WIDTH  first RAM address to read; latched on start.
- num_patches  in  ADDR_WIDTH+1  number of words to stream (0..DEPTH); latched on start.
- ram_ren  out  1  RAM read enable.
- ram_radr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM read data; valid the cycle after ram_ren.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word; a transfer happens when out_valid && out_ready.
- out_data  out  DATA_WIDTH  patch word.
- out_last  out  1  high with the final word of the transfer.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset, asynchronous, all outputs 0: state=IDLE, counters 0, FIFO empty, in-flight flag 0, ram_ren=0, ram_radr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM: on start with num_patches!=0. The cycle start is sampled, latch base_adr into the read address and num_patches; clear the issue and delivered counters.
  - IDLE -> DONE: on start with num_patches==0. No RAM reads and no out_valid.
  - STREAM -> DONE: on the handshake of the final word (delivered count reaches num_patches).
  - DONE -> IDLE: unconditionally after one cycle. done=1 only in DONE.
- start is ignored outside IDLE.
- ram_ren is combinational and asserts in STREAM when issued < num_patches && (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready.
  - This sustains 1 word/cycle while out_ready is held high.
- ram_radr is the registered read address. It increments by 1 on each ram_ren and wraps modulo DEPTH (e.g. 127 -> 0).
- The in-flight flag is a register equal to the previous cycle's ram_ren. When it is set, ram_rdata is pushed into the FIFO at the next edge.
- FIFO: 2 entries, registered head.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Simultaneous push and pop are allowed in the same cycle.
  - The FIFO must never overflow; this is guaranteed by the credit rule above.
- out_last = out_valid && (delivered == num_patches-1).
- Latency:
  - start in cycle 0 -> ram_ren=1 with ram_radr=base_adr in cycle 1 -> word in FIFO, out_valid=1 in cycle 3.
  - done pulses in the cycle after the last handshake.
- Backpressure: with out_ready=0, out_valid and out_data hold stable; at most 2 words are outstanding (FIFO + in-flight).
- num_patches==DEPTH: reads every address exactly once, starting at base_adr and wrapping.
- Reset mid-transfer: all state is cleared immediately. A RAM read in flight at reset is discarded and never appears on out_data.
- Counter widths are ADDR_WIDTH+1 to represent DEPTH.

Decomposition:
- Shared package (query_mem_pkg): DATA_WIDTH/ADDR_WIDTH/DEPTH defaults, the FSM state encoding constants, and the count width (ADDR_WIDTH+1). The same constants are shared with the write-side wrapper.
- One sub-module: patch_out_fifo2 (2-entry synchronous FIFO with push/pop/count and async active-low reset).
- Credit logic and FSM stay in the top level.

Test Plan:
- base_adr=0, num_patches=5, out_ready=1, RAM preloaded with word[i]=i+100:
  - out_data 100..104 on consecutive cycles starting cycle 3.
  - out_last on 104; done one cycle later; busy low after that.
- base_adr=126, num_patches=4, RAM word[i]=i:
  - ram_radr sequence 126,127,0,1; out_data 126,127,0,1.
- num_patches=6, out_ready toggling 1,0,0,1,... pseudo-randomly:
  - all 6 words delivered in order, none duplicated or dropped.
  - out_data stable while out_valid && !out_ready.
  - ram_ren never asserts when the FIFO plus in-flight words already total 2.
- num_patches=0 on start:
  - no ram_ren, no out_valid, done pulses exactly once, busy high for exactly one cycle (the DONE cycle).
- start pulsed again mid-transfer (num_patches=8), then rst_n low during cycle 5, then released:
  - the second start is ignored.
  - after reset, all outputs are 0 and the in-flight word is never output.
  - a new start with num_patches=2 streams correctly.
- num_patches=128, base_adr=64, out_ready=1:
  - 128 words delivered, addresses 64..127,0..63.
  - throughput is 1 word/cycle.
